// File: rtl/ppu_vram_port_if.sv
// PPU-side request/response bus of the VRAM access port.
// The requester (PPU fetch / $2007 logic) uses master; the port uses slave.
interface ppu_vram_port_if #(
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [15:0]       addr_in;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr_in, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr_in, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/ppu_vram_port.sv
// Handshaked PPU VRAM port: accepts one access per request, translates the PPU
// address (pattern passthrough, nametable mirroring, palette aliasing) and drives a fixed-latency RAM.
module ppu_vram_port #(
  parameter int          DATA_W   = 8,
  parameter int          MEM_LAT  = 1,
  parameter logic [15:0] NT_BASE  = 16'h2000,
  parameter logic [15:0] PAL_BASE = 16'h3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mirror_mode,
  ppu_vram_port_if.slave    bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [15:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready;

  // Bits 15:14 of the PPU address never reach here: the PPU bus mirrors every 16 KiB.
  function automatic logic [15:0] translate(input logic [13:0] a, input logic [2:0] mode);
    logic [11:0] n;
    logic [1:0]  t;
    logic [1:0]  page;
    logic [4:0]  p;
    n    = a[11:0];
    t    = n[11:10];
    p    = a[4:0];
    page = 2'b00;
    if (!a[13]) begin
      translate = {2'b00, a};
    end else if (a[13:8] != 6'h3F) begin
      case (mode)
        3'd0:    page = {1'b0, t[1]};
        3'd2:    page = 2'b00;
        3'd3:    page = 2'b01;
        3'd4:    page = t;
        default: page = {1'b0, t[0]};
      endcase
      translate = NT_BASE + {4'b0000, page, n[9:0]};
    end else begin
      // Sprite-palette entry 0 of each group aliases the background entry.
      if (p[1:0] == 2'b00) p[4] = 1'b0;
      translate = PAL_BASE + {11'b0, p};
    end
  endfunction

  assign ready = (state_q == IDLE) || (state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.req) begin
          state_d = ISSUE;
          we_d    = bus.we;
          wdata_d = bus.wdata;
          addr_d  = translate(bus.addr_in[13:0], mirror_mode);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(MEM_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready  = ready;
  assign bus.rvalid = (state_q == DONE);
  assign bus.rdata  = rdata_q;
  assign mem_en     = (state_q == ISSUE);
  assign mem_we     = mem_en & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Bench for ppu_vram_port: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// both backed by a shared byte-array memory with a per-instance read-latency pipe.
module tb_ppu_vram_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mirror_mode;

  ppu_vram_port_if #(.DATA_W(8)) bus1 ();
  ppu_vram_port_if #(.DATA_W(8)) bus3 ();

  logic        m1_en, m1_we, m3_en, m3_we;
  logic [15:0] m1_addr, m3_addr;
  logic [7:0]  m1_wdata, m1_rdata, m3_wdata, m3_rdata;

  ppu_vram_port #(.DATA_W(8), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .mirror_mode(mirror_mode), .bus(bus1.slave),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
  );

  ppu_vram_port #(.DATA_W(8), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .mirror_mode(mirror_mode), .bus(bus3.slave),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr),
    .mem_wdata(m3_wdata), .mem_rdata(m3_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten bytes return a fixed address pattern.
  logic [7:0] vmem  [65536];
  bit         wflag [65536];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];

  function automatic logic [7:0] rd_model(input logic [15:0] a);
    if (wflag[a]) return vmem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (m1_en && m1_we) begin
      vmem[m1_addr]  <= m1_wdata;
      wflag[m1_addr] <= 1'b1;
    end
    if (m3_en && m3_we) begin
      vmem[m3_addr]  <= m3_wdata;
      wflag[m3_addr] <= 1'b1;
    end
    pipe1    <= (m1_en && !m1_we) ? rd_model(m1_addr) : 8'h00;
    pipe3[0] <= (m3_en && !m3_we) ? rd_model(m3_addr) : 8'h00;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign m1_rdata = pipe1;
  assign m3_rdata = pipe3[2];

  // Selected-instance view used by the access tasks.
  int          cur = 1;
  logic        s_ready, s_rvalid, s_en, s_we;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata, s_rdata;

  always_comb begin
    if (cur == 3) begin
      s_ready = bus3.ready; s_rvalid = bus3.rvalid; s_rdata = bus3.rdata;
      s_en = m3_en; s_we = m3_we; s_addr = m3_addr; s_wdata = m3_wdata;
    end else begin
      s_ready = bus1.ready; s_rvalid = bus1.rvalid; s_rdata = bus1.rdata;
      s_en = m1_en; s_we = m1_we; s_addr = m1_addr; s_wdata = m1_wdata;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic select(input int c);
    cur = c;
    #1;
  endtask

  task automatic drive(input bit r, input bit w, input logic [15:0] a, input logic [7:0] d);
    if (cur == 3) begin
      bus3.req = r; bus3.we = w; bus3.addr_in = a; bus3.wdata = d;
    end else begin
      bus1.req = r; bus1.we = w; bus1.addr_in = a; bus1.wdata = d;
    end
  endtask

  // Called just after a rising edge; returns after the response cycle (or the
  // following one when post is set).
  task automatic access(input string tag, input bit w, input logic [2:0] mode,
                        input logic [15:0] a, input logic [7:0] d,
                        input logic [15:0] ea, input int lat, input bit post);
    int         n;
    logic [7:0] exp_rd;
    mirror_mode = mode;
    drive(1'b1, w, a, d);
    n = 0;
    while (!s_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!s_ready) begin
      check({tag, "_accept_timeout"}, 32'(0), 32'(1));
      drive(1'b0, 1'b0, 16'h0, 8'h0);
      return;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    mirror_mode = mode + 3'd1;
    check({tag, "_mem_en"},   32'(s_en),    32'(1));
    check({tag, "_mem_we"},   32'(s_we),    32'(w));
    check({tag, "_mem_addr"}, 32'(s_addr),  32'(ea));
    check({tag, "_busy"},     32'(s_ready), 32'(0));
    exp_rd = rd_model(ea);
    if (w) begin
      check({tag, "_mem_wdata"}, 32'(s_wdata), 32'(d));
      @(posedge clk); #1;
      check({tag, "_wr_ready"}, 32'(s_ready), 32'(1));
      check({tag, "_wr_en_off"}, 32'(s_en), 32'(0));
    end else begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!s_rvalid && n < 20);
      check({tag, "_rd_latency"}, 32'(n), 32'(lat + 1));
      check({tag, "_rdata"}, 32'(s_rdata), 32'(exp_rd));
      if (post) begin
        @(posedge clk); #1;
        check({tag, "_rvalid_pulse"}, 32'(s_rvalid), 32'(0));
        check({tag, "_rdata_hold"}, 32'(s_rdata), 32'(exp_rd));
      end
    end
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  mode;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic seen;
    vecs[0]  = '{1'b1, 3'd0, 16'h2C05, 8'h3C, 16'h2405};
    vecs[1]  = '{1'b0, 3'd1, 16'h2C05, 8'h00, 16'h2405};
    vecs[2]  = '{1'b0, 3'd3, 16'h2C05, 8'h00, 16'h2405};
    vecs[3]  = '{1'b0, 3'd4, 16'h2C05, 8'h00, 16'h2C05};
    vecs[4]  = '{1'b0, 3'd0, 16'h3F10, 8'h00, 16'h3000};
    vecs[5]  = '{1'b0, 3'd0, 16'h3F14, 8'h00, 16'h3004};
    vecs[6]  = '{1'b0, 3'd0, 16'h3F11, 8'h00, 16'h3011};
    vecs[7]  = '{1'b0, 3'd0, 16'h3F31, 8'h00, 16'h3011};
    vecs[8]  = '{1'b0, 3'd0, 16'h7F04, 8'h00, 16'h3004};
    vecs[9]  = '{1'b0, 3'd0, 16'h0ABC, 8'h00, 16'h0ABC};
    vecs[10] = '{1'b0, 3'd1, 16'h3805, 8'h00, 16'h2005};
    vecs[11] = '{1'b0, 3'd2, 16'h2BFF, 8'h00, 16'h23FF};
    vecs[12] = '{1'b0, 3'd6, 16'h2400, 8'h00, 16'h2400};
    vecs[13] = '{1'b1, 3'd0, 16'h1FFF, 8'h77, 16'h1FFF};
    vecs[14] = '{1'b0, 3'd0, 16'hDFFF, 8'h00, 16'h1FFF};
    vecs[15] = '{1'b0, 3'd0, 16'h3FFF, 8'h00, 16'h301F};
    vecs[16] = '{1'b1, 3'd0, 16'h3F10, 8'h99, 16'h3000};
    vecs[17] = '{1'b0, 3'd0, 16'h3F1C, 8'h00, 16'h300C};
    vecs[18] = '{1'b0, 3'd0, 16'h3F00, 8'h00, 16'h3000};
    vecs[19] = '{1'b0, 3'd3, 16'hE000, 8'h00, 16'h2400};

    rst = 1'b1;
    mirror_mode = 3'd0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr_in = 16'h0; bus1.wdata = 8'h0;
    bus3.req = 1'b0; bus3.we = 1'b0; bus3.addr_in = 16'h0; bus3.wdata = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 1; c <= 3; c += 2) begin
      select(c);
      check("rst_ready",     32'(s_ready),  32'(1));
      check("rst_rvalid",    32'(s_rvalid), 32'(0));
      check("rst_rdata",     32'(s_rdata),  32'(0));
      check("rst_mem_en",    32'(s_en),     32'(0));
      check("rst_mem_we",    32'(s_we),     32'(0));
      check("rst_mem_addr",  32'(s_addr),   32'(0));
      check("rst_mem_wdata", 32'(s_wdata),  32'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    select(1);
    for (int i = 0; i < 20; i++) begin
      access($sformatf("vec%0d", i), vecs[i].we, vecs[i].mode, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_addr, 1, 1'b1);
    end

    // Back-to-back: second request issued during the rvalid cycle.
    access("b2b_a", 1'b0, 3'd0, 16'h3F11, 8'h00, 16'h3011, 1, 1'b0);
    check("b2b_done_ready",  32'(s_ready),  32'(1));
    check("b2b_done_rvalid", 32'(s_rvalid), 32'(1));
    access("b2b_b", 1'b0, 3'd0, 16'h0ABC, 8'h00, 16'h0ABC, 1, 1'b1);

    // Seed $A5 at palette $3004 for the long-latency instance.
    access("seed", 1'b1, 3'd0, 16'h3F04, 8'hA5, 16'h3004, 1, 1'b1);

    // MEM_LAT=3: read plus a request pulse while busy that must be dropped.
    select(3);
    check("lat3_ready_idle", 32'(s_ready), 32'(1));
    drive(1'b1, 1'b0, 16'h3F14, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    check("lat3_mem_en",   32'(s_en),   32'(1));
    check("lat3_mem_addr", 32'(s_addr), 32'(16'h3004));
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0100, 8'h00);
    @(posedge clk); #1;
    check("lat3_busy_no_en", 32'(s_en),    32'(0));
    check("lat3_busy_ready", 32'(s_ready), 32'(0));
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    @(posedge clk); #1;
    check("lat3_no_early_rvalid", 32'(s_rvalid), 32'(0));
    @(posedge clk); #1;
    check("lat3_rvalid", 32'(s_rvalid), 32'(1));
    check("lat3_rdata",  32'(s_rdata),  32'(8'hA5));
    @(posedge clk); #1;
    check("lat3_rvalid_pulse", 32'(s_rvalid), 32'(0));
    check("lat3_rdata_hold",   32'(s_rdata),  32'(8'hA5));
    check("lat3_ignored_req",  32'(s_en),     32'(0));

    // Reset during WAIT aborts the access.
    drive(1'b1, 1'b0, 16'h0123, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    check("rstw_mem_en", 32'(s_en), 32'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_ready",    32'(s_ready),  32'(1));
    check("rstw_rvalid",   32'(s_rvalid), 32'(0));
    check("rstw_rdata",    32'(s_rdata),  32'(0));
    check("rstw_mem_en",   32'(s_en),     32'(0));
    check("rstw_mem_addr", 32'(s_addr),   32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (s_rvalid) seen = 1'b1;
    end
    check("rstw_no_rvalid", 32'(seen), 32'(0));
    access("post_rst", 1'b0, 3'd0, 16'h3F04, 8'h00, 16'h3004, 3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
